// File: rtl/hazard_scoreboard.sv
// Issue-side hazard scoreboard.
// Tracks in-flight register writes in the EX and MEM slots plus the single MUL/DIV unit, and
// stalls the ID stage only when forwarding cannot supply an operand (load-use, pending MUL/DIV
// result) or when the MUL/DIV unit is already occupied.

module hazard_scoreboard #(
    parameter int unsigned NUM_REGS   = 16,
    parameter int unsigned REG_W      = 4,
    parameter int unsigned MD_LATENCY = 4
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                issue_valid_i,
    input  logic [REG_W-1:0]    register_op1_id_i,
    input  logic [REG_W-1:0]    register_op2_id_i,
    input  logic [REG_W-1:0]    register_dest_id_i,
    input  logic [1:0]          reg_write_id_i,
    input  logic                is_load_id_i,
    input  logic                is_md_id_i,
    input  logic                flush_i,
    output logic                stall_o,
    output logic [NUM_REGS-1:0] pending_mask_o,
    output logic                md_busy_o,
    output logic                md_done_o
);

    // Counter only has to hold MD_LATENCY-1 down to 0.
    localparam int unsigned     CntW    = $clog2(MD_LATENCY);
    localparam logic [CntW-1:0] CntInit = CntW'(MD_LATENCY - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } md_state_e;

    // Tracking slots
    logic             ex_v_q, ex_v_d;
    logic [REG_W-1:0] ex_dest_q, ex_dest_d;
    logic             ex_load_q, ex_load_d;
    logic             mem_v_q, mem_v_d;
    logic [REG_W-1:0] mem_dest_q, mem_dest_d;

    // MUL/DIV tracking
    md_state_e        md_state_q, md_state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [REG_W-1:0] md_dest_q, md_dest_d;

    // Decode of the ID instruction
    logic id_writes;
    logic id_reads_ex;
    logic id_reads_md;
    logic id_waw_md;
    logic md_active;
    logic load_use;
    logic md_stall;
    logic accepted;

    // Classify the ID instruction against the tracked producers.
    always_comb begin
        id_writes   = (reg_write_id_i != 2'b00) && (register_dest_id_i != '0);
        id_reads_ex = (ex_dest_q != '0) &&
                      ((register_op1_id_i == ex_dest_q) || (register_op2_id_i == ex_dest_q));
        id_reads_md = (md_dest_q != '0) &&
                      ((register_op1_id_i == md_dest_q) || (register_op2_id_i == md_dest_q));
        id_waw_md   = id_writes && (register_dest_id_i == md_dest_q);
        md_active   = (md_state_q == StBusy) || (md_state_q == StDone);
    end

    // Stall generation; a flush overrides any hazard since the ID instruction is squashed.
    always_comb begin
        load_use = issue_valid_i && ex_v_q && ex_load_q && id_reads_ex;
        md_stall = issue_valid_i && md_active && (id_reads_md || id_waw_md || is_md_id_i);
        stall_o  = (load_use || md_stall) && !flush_i;
        accepted = issue_valid_i && !stall_o && !flush_i;
    end

    // Slot advance: MEM takes EX, EX takes an accepted non-MD writer or becomes a bubble.
    always_comb begin
        ex_v_d     = accepted && id_writes && !is_md_id_i;
        ex_dest_d  = register_dest_id_i;
        ex_load_d  = is_load_id_i;
        mem_v_d    = ex_v_q;
        mem_dest_d = ex_dest_q;
    end

    // MUL/DIV FSM next state: BUSY lasts exactly MD_LATENCY cycles, DONE one cycle.
    always_comb begin
        md_state_d = md_state_q;
        cnt_d      = cnt_q;
        md_dest_d  = md_dest_q;
        unique case (md_state_q)
            StIdle: begin
                if (accepted && is_md_id_i) begin
                    md_state_d = StBusy;
                    cnt_d      = CntInit;
                    md_dest_d  = id_writes ? register_dest_id_i : '0;
                end
            end
            StBusy: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    md_state_d = StDone;
                end
            end
            StDone: begin
                md_state_d = StIdle;
            end
            default: begin
                md_state_d = StIdle;
            end
        endcase
    end

    // Registers with synchronous reset; reset also aborts an in-flight MUL/DIV.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ex_v_q     <= 1'b0;
            ex_dest_q  <= '0;
            ex_load_q  <= 1'b0;
            mem_v_q    <= 1'b0;
            mem_dest_q <= '0;
            md_state_q <= StIdle;
            cnt_q      <= '0;
            md_dest_q  <= '0;
        end else begin
            ex_v_q     <= ex_v_d;
            ex_dest_q  <= ex_dest_d;
            ex_load_q  <= ex_load_d;
            mem_v_q    <= mem_v_d;
            mem_dest_q <= mem_dest_d;
            md_state_q <= md_state_d;
            cnt_q      <= cnt_d;
            md_dest_q  <= md_dest_d;
        end
    end

    // Pending-write mask from state only; register 0 is never pending.
    always_comb begin
        pending_mask_o = '0;
        if (ex_v_q) begin
            pending_mask_o[ex_dest_q] = 1'b1;
        end
        if (mem_v_q) begin
            pending_mask_o[mem_dest_q] = 1'b1;
        end
        if (md_active) begin
            pending_mask_o[md_dest_q] = 1'b1;
        end
        pending_mask_o[0] = 1'b0;
    end

    // FSM status outputs.
    always_comb begin
        md_busy_o = (md_state_q == StBusy);
        md_done_o = (md_state_q == StDone);
    end

    // Structural invariants.
    a_busy_done_excl: assert property (@(posedge clk_i) disable iff (reset_i)
        !(md_busy_o && md_done_o));
    a_no_stall_idle: assert property (@(posedge clk_i) disable iff (reset_i)
        !issue_valid_i |-> !stall_o);
    a_flush_no_stall: assert property (@(posedge clk_i) disable iff (reset_i)
        flush_i |-> !stall_o);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: per-scenario stimulus tables with hand-derived expectations,
// pushed to a scoreboard queue as each cycle is driven and popped when outputs are sampled.

module tb_hazard_scoreboard;

    logic        clk;
    logic        reset;
    logic        issue_valid;
    logic [3:0]  op1, op2, dest;
    logic [1:0]  reg_write;
    logic        is_load, is_md, flush;
    logic        stall;
    logic [15:0] pending_mask;
    logic        md_busy, md_done;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic       rst;
        logic       iv;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] d;
        logic [1:0] rw;
        logic       ld;
        logic       md;
        logic       fl;
    } stim_t;

    typedef struct packed {
        logic        stall;
        logic        busy;
        logic        done;
        logic [15:0] pm;
    } exp_t;

    exp_t sb_q[$];

    hazard_scoreboard #(
        .NUM_REGS  (16),
        .REG_W     (4),
        .MD_LATENCY(4)
    ) dut (
        .clk_i             (clk),
        .reset_i           (reset),
        .issue_valid_i     (issue_valid),
        .register_op1_id_i (op1),
        .register_op2_id_i (op2),
        .register_dest_id_i(dest),
        .reg_write_id_i    (reg_write),
        .is_load_id_i      (is_load),
        .is_md_id_i        (is_md),
        .flush_i           (flush),
        .stall_o           (stall),
        .pending_mask_o    (pending_mask),
        .md_busy_o         (md_busy),
        .md_done_o         (md_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t st(logic iv, logic [3:0] a, logic [3:0] b, logic [3:0] d,
                                 logic [1:0] rw, logic ld, logic md, logic fl);
        stim_t s;
        s.rst = 1'b0; s.iv = iv; s.a = a; s.b = b; s.d = d;
        s.rw = rw; s.ld = ld; s.md = md; s.fl = fl;
        return s;
    endfunction

    function automatic stim_t nop();
        return st(1'b0, 4'd0, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic exp_t ex(logic s, logic bz, logic dn, logic [15:0] pm);
        exp_t e;
        e.stall = s; e.busy = bz; e.done = dn; e.pm = pm;
        return e;
    endfunction

    function automatic exp_t observe();
        return ex(stall, md_busy, md_done, pending_mask);
    endfunction

    task automatic apply(input stim_t s);
        reset       = s.rst;
        issue_valid = s.iv;
        op1         = s.a;
        op2         = s.b;
        dest        = s.d;
        reg_write   = s.rw;
        is_load     = s.ld;
        is_md       = s.md;
        flush       = s.fl;
    endtask

    task automatic test_reset();
        stim_t s[$];
        exp_t  e[$];
        exp_t  got, want;
        stim_t x;
        x = st(1, 1, 2, 3, 1, 0, 1, 0); x.rst = 1'b1; s.push_back(x); e.push_back(ex(0, 0, 0, 16'h0));
        x = st(1, 1, 2, 3, 1, 1, 0, 0); x.rst = 1'b1; s.push_back(x); e.push_back(ex(0, 0, 0, 16'h0));
        s.push_back(nop()); e.push_back(ex(0, 0, 0, 16'h0));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            sb_q.push_back(e[i]);
            @(negedge clk);
            got  = observe();
            want = sb_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_errors++;
                $display("FAIL reset[%0d]: stall/busy/done/pmask got %b/%b/%b/%h want %b/%b/%b/%h",
                         i, got.stall, got.busy, got.done, got.pm,
                         want.stall, want.busy, want.done, want.pm);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        stim_t s[$];
        exp_t  e[$];
        exp_t  got, want;
        s.push_back(st(1, 1, 2, 3, 1, 1, 0, 0)); e.push_back(ex(0, 0, 0, 16'h0000)); // load r3
        s.push_back(st(1, 3, 1, 4, 1, 0, 0, 0)); e.push_back(ex(1, 0, 0, 16'h0008)); // add r4 stalls
        s.push_back(st(1, 3, 1, 4, 1, 0, 0, 0)); e.push_back(ex(0, 0, 0, 16'h0008)); // accepted
        s.push_back(st(1, 4, 0, 0, 0, 0, 0, 0)); e.push_back(ex(0, 0, 0, 16'h0010)); // ALU in EX
        s.push_back(st(1, 0, 4, 0, 0, 0, 0, 0)); e.push_back(ex(0, 0, 0, 16'h0010)); // ALU in MEM
        s.push_back(nop());                      e.push_back(ex(0, 0, 0, 16'h0000));
        s.push_back(st(1, 1, 2, 9, 2, 1, 0, 0)); e.push_back(ex(0, 0, 0, 16'h0000)); // load r9
        s.push_back(nop());                      e.push_back(ex(0, 0, 0, 16'h0200));
        s.push_back(st(1, 9, 0, 0, 0, 0, 0, 0)); e.push_back(ex(0, 0, 0, 16'h0200)); // load in MEM
        s.push_back(nop());                      e.push_back(ex(0, 0, 0, 16'h0000));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            sb_q.push_back(e[i]);
            @(negedge clk);
            got  = observe();
            want = sb_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_errors++;
                $display("FAIL load_use[%0d]: stall/busy/done/pmask got %b/%b/%b/%h want %b/%b/%b/%h",
                         i, got.stall, got.busy, got.done, got.pm,
                         want.stall, want.busy, want.done, want.pm);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reg0();
        stim_t s[$];
        exp_t  e[$];
        exp_t  got, want;
        s.push_back(st(1, 1, 2, 0, 1, 1, 0, 0)); e.push_back(ex(0, 0, 0, 16'h0)); // load r0
        s.push_back(st(1, 0, 0, 5, 1, 0, 0, 0)); e.push_back(ex(0, 0, 0, 16'h0)); // reads r0
        s.push_back(nop());                      e.push_back(ex(0, 0, 0, 16'h0020));
        s.push_back(st(1, 1, 2, 3, 0, 1, 0, 0)); e.push_back(ex(0, 0, 0, 16'h0020)); // load, no write
        s.push_back(st(1, 3, 3, 0, 0, 0, 0, 0)); e.push_back(ex(0, 0, 0, 16'h0));
        s.push_back(nop());                      e.push_back(ex(0, 0, 0, 16'h0));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            sb_q.push_back(e[i]);
            @(negedge clk);
            got  = observe();
            want = sb_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_errors++;
                $display("FAIL reg0[%0d]: stall/busy/done/pmask got %b/%b/%b/%h want %b/%b/%b/%h",
                         i, got.stall, got.busy, got.done, got.pm,
                         want.stall, want.busy, want.done, want.pm);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_md_raw();
        stim_t s[$];
        exp_t  e[$];
        exp_t  got, want;
        s.push_back(st(1, 1, 2, 5, 1, 0, 1, 0)); e.push_back(ex(0, 0, 0, 16'h0000)); // mul r5
        for (int k = 0; k < 4; k++) begin
            s.push_back(st(1, 5, 1, 8, 1, 0, 0, 0)); e.push_back(ex(1, 1, 0, 16'h0020));
        end
        s.push_back(st(1, 5, 1, 8, 1, 0, 0, 0)); e.push_back(ex(1, 0, 1, 16'h0020)); // DONE
        s.push_back(st(1, 5, 1, 8, 1, 0, 0, 0)); e.push_back(ex(0, 0, 0, 16'h0000)); // issues
        s.push_back(nop());                      e.push_back(ex(0, 0, 0, 16'h0100));
        s.push_back(nop());                      e.push_back(ex(0, 0, 0, 16'h0100));
        s.push_back(nop());                      e.push_back(ex(0, 0, 0, 16'h0000));
        s.push_back(st(1, 1, 2, 5, 1, 0, 1, 0)); e.push_back(ex(0, 0, 0, 16'h0000)); // mul r5
        s.push_back(st(1, 1, 2, 6, 1, 0, 0, 0)); e.push_back(ex(0, 1, 0, 16'h0020)); // indep add
        s.push_back(nop());                      e.push_back(ex(0, 1, 0, 16'h0060));
        s.push_back(nop());                      e.push_back(ex(0, 1, 0, 16'h0060));
        s.push_back(nop());                      e.push_back(ex(0, 1, 0, 16'h0020));
        s.push_back(nop());                      e.push_back(ex(0, 0, 1, 16'h0020));
        s.push_back(nop());                      e.push_back(ex(0, 0, 0, 16'h0000));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            sb_q.push_back(e[i]);
            @(negedge clk);
            got  = observe();
            want = sb_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_errors++;
                $display("FAIL md_raw[%0d]: stall/busy/done/pmask got %b/%b/%b/%h want %b/%b/%b/%h",
                         i, got.stall, got.busy, got.done, got.pm,
                         want.stall, want.busy, want.done, want.pm);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_md_struct_waw();
        stim_t s[$];
        exp_t  e[$];
        exp_t  got, want;
        s.push_back(st(1, 1, 2, 5, 1, 0, 1, 0)); e.push_back(ex(0, 0, 0, 16'h0)); // mul r5
        s.push_back(st(1, 1, 2, 5, 1, 0, 0, 0)); e.push_back(ex(1, 1, 0, 16'h0020)); // WAW r5
        s.push_back(st(1, 1, 2, 7, 1, 0, 1, 0)); e.push_back(ex(1, 1, 0, 16'h0020)); // div r7
        s.push_back(st(1, 1, 2, 7, 1, 0, 1, 0)); e.push_back(ex(1, 1, 0, 16'h0020));
        s.push_back(st(1, 1, 2, 7, 1, 0, 1, 0)); e.push_back(ex(1, 1, 0, 16'h0020));
        s.push_back(st(1, 1, 2, 7, 1, 0, 1, 0)); e.push_back(ex(1, 0, 1, 16'h0020));
        s.push_back(st(1, 1, 2, 7, 1, 0, 1, 0)); e.push_back(ex(0, 0, 0, 16'h0));  // div issues
        s.push_back(st(1, 1, 2, 7, 2, 0, 0, 0)); e.push_back(ex(1, 1, 0, 16'h0080)); // WAW r7
        s.push_back(st(1, 1, 2, 7, 2, 0, 0, 1)); e.push_back(ex(0, 1, 0, 16'h0080)); // flush wins
        s.push_back(st(0, 7, 7, 7, 1, 0, 1, 0)); e.push_back(ex(0, 1, 0, 16'h0080)); // iv=0
        s.push_back(nop());                      e.push_back(ex(0, 1, 0, 16'h0080));
        s.push_back(nop());                      e.push_back(ex(0, 0, 1, 16'h0080));
        s.push_back(nop());                      e.push_back(ex(0, 0, 0, 16'h0));
        s.push_back(st(1, 1, 2, 5, 0, 0, 1, 0)); e.push_back(ex(0, 0, 0, 16'h0));  // md, no write
        s.push_back(st(1, 5, 0, 0, 0, 0, 0, 0)); e.push_back(ex(0, 1, 0, 16'h0));
        s.push_back(nop());                      e.push_back(ex(0, 1, 0, 16'h0));
        s.push_back(nop());                      e.push_back(ex(0, 1, 0, 16'h0));
        s.push_back(nop());                      e.push_back(ex(0, 1, 0, 16'h0));
        s.push_back(nop());                      e.push_back(ex(0, 0, 1, 16'h0));
        s.push_back(nop());                      e.push_back(ex(0, 0, 0, 16'h0));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            sb_q.push_back(e[i]);
            @(negedge clk);
            got  = observe();
            want = sb_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_errors++;
                $display("FAIL md_struct_waw[%0d]: stall/busy/done/pmask got %b/%b/%b/%h want %b/%b/%b/%h",
                         i, got.stall, got.busy, got.done, got.pm,
                         want.stall, want.busy, want.done, want.pm);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flush();
        stim_t s[$];
        exp_t  e[$];
        exp_t  got, want;
        s.push_back(st(1, 1, 2, 3, 1, 1, 0, 0)); e.push_back(ex(0, 0, 0, 16'h0000)); // load r3
        s.push_back(st(1, 3, 1, 4, 1, 0, 0, 1)); e.push_back(ex(0, 0, 0, 16'h0008)); // flushed
        s.push_back(nop());                      e.push_back(ex(0, 0, 0, 16'h0008));
        s.push_back(nop());                      e.push_back(ex(0, 0, 0, 16'h0000));
        s.push_back(st(1, 1, 2, 3, 1, 1, 0, 1)); e.push_back(ex(0, 0, 0, 16'h0000)); // load flushed
        s.push_back(nop());                      e.push_back(ex(0, 0, 0, 16'h0000));
        s.push_back(st(1, 1, 2, 5, 1, 0, 1, 1)); e.push_back(ex(0, 0, 0, 16'h0000)); // mul flushed
        s.push_back(nop());                      e.push_back(ex(0, 0, 0, 16'h0000));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            sb_q.push_back(e[i]);
            @(negedge clk);
            got  = observe();
            want = sb_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_errors++;
                $display("FAIL flush[%0d]: stall/busy/done/pmask got %b/%b/%b/%h want %b/%b/%b/%h",
                         i, got.stall, got.busy, got.done, got.pm,
                         want.stall, want.busy, want.done, want.pm);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_busy();
        stim_t s[$];
        exp_t  e[$];
        exp_t  got, want;
        stim_t x;
        s.push_back(st(1, 1, 2, 5, 1, 0, 1, 0)); e.push_back(ex(0, 0, 0, 16'h0000)); // mul r5
        s.push_back(st(1, 1, 2, 9, 1, 1, 0, 0)); e.push_back(ex(0, 1, 0, 16'h0020)); // load r9
        x = nop(); x.rst = 1'b1;
        s.push_back(x);                          e.push_back(ex(0, 1, 0, 16'h0220)); // cnt=2
        s.push_back(st(1, 5, 9, 0, 0, 0, 0, 0)); e.push_back(ex(0, 0, 0, 16'h0000));
        s.push_back(nop());                      e.push_back(ex(0, 0, 0, 16'h0000));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            sb_q.push_back(e[i]);
            @(negedge clk);
            got  = observe();
            want = sb_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_errors++;
                $display("FAIL reset_mid_busy[%0d]: stall/busy/done/pmask got %b/%b/%b/%h want %b/%b/%b/%h",
                         i, got.stall, got.busy, got.done, got.pm,
                         want.stall, want.busy, want.done, want.pm);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        stim_t r;
        r = nop();
        r.rst = 1'b1;
        apply(r);
        @(posedge clk); #1;
        test_reset();
        test_load_use();
        test_reg0();
        test_md_raw();
        test_md_struct_waw();
        test_flush();
        test_reset_mid_busy();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
